// File: rtl/lbp_host_mem.sv
// Host-side memory responder for the LBP engine: gray image RAM, LBP result RAM, load/serve/done flow.
// Optional border-address checker on LBP writes is enabled by defining LBP_ADDR_CHECK_EN.
module lbp_host_mem #(
    parameter int unsigned IMG_W = 128,
    parameter int unsigned IMG_H = 128,
    parameter int unsigned AW    = 14,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    input  logic          load_start,
    output logic          gray_ready,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic [DW-1:0] gray_data,
    input  logic          lbp_valid,
    input  logic [AW-1:0] lbp_addr,
    input  logic [DW-1:0] lbp_data,
    input  logic          finish,
    output logic          done,
    output logic [AW:0]   wr_cnt,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          err
);

    localparam int unsigned NPix = IMG_W * IMG_H;
    localparam int unsigned CW   = $clog2(IMG_W);
    localparam int unsigned RW   = AW - CW;

    typedef enum logic [1:0] {StLoad, StServe, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] load_cnt_q;
    logic [DW-1:0] gray_mem [NPix];
    logic [DW-1:0] lbp_mem  [NPix];

    logic load_fire;
    logic load_last;
    logic lbp_fire;
    logic restart;

    assign load_ready = (state_q == StLoad);
    assign gray_ready = (state_q == StServe);
    assign done       = (state_q == StDone);

    assign load_fire = load_valid & load_ready;
    assign load_last = (load_cnt_q == AW'(NPix - 1));
    assign lbp_fire  = lbp_valid & gray_ready;
    assign restart   = load_start & done;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad:  if (load_fire && load_last) state_d = StServe;
            StServe: if (finish) state_d = StDone;
            StDone:  if (load_start) state_d = StLoad;
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StLoad;
            load_cnt_q <= '0;
            wr_cnt     <= '0;
            gray_data  <= '0;
            rd_data    <= '0;
        end else begin
            state_q <= state_d;
            if (load_fire) begin
                load_cnt_q <= load_last ? '0 : load_cnt_q + AW'(1);
            end
            if (restart) begin
                wr_cnt <= '0;
            end else if (lbp_fire && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + (AW+1)'(1);
            end
            if (gray_req && gray_ready) begin
                gray_data <= gray_mem[gray_addr];
            end
            rd_data <= lbp_mem[rd_addr];
        end
    end

    // RAM arrays carry no reset; contents survive reset and load_start.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            gray_mem[load_cnt_q] <= load_data;
        end
        if (lbp_fire) begin
            lbp_mem[lbp_addr] <= lbp_data;
        end
    end

`ifdef LBP_ADDR_CHECK_EN
    logic          err_q;
    logic [CW-1:0] lbp_col;
    logic [RW-1:0] lbp_row;
    logic          border;

    assign lbp_col = lbp_addr[CW-1:0];
    assign lbp_row = lbp_addr[AW-1:CW];
    assign border  = (lbp_row == '0) || (lbp_row == RW'(IMG_H - 1)) ||
                     (lbp_col == '0) || (lbp_col == CW'(IMG_W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (restart) begin
            err_q <= 1'b0;
        end else if (lbp_fire && border) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
